// File: rtl/uart_pkg.sv
// Shared ASCII constants and the record formatter state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STB_HI = 2'd2,
    STB_LO = 2'd3
  } fmt_state_e;

endpackage

// File: rtl/uart_hex_formatter_if.sv
// Record-in / character-out bundle between a record producer and the formatter.
interface uart_hex_formatter_if;
  logic [15:0] addr;
  logic [7:0]  value;
  logic        req;
  logic        ready;
  logic [7:0]  data;
  logic        data_strobe;

  modport master (output addr, value, req, input ready, data, data_strobe);
  modport slave  (input addr, value, req, output ready, data, data_strobe);
endinterface

// File: rtl/nibble_to_hex_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit converter.
module nibble_to_hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end
endmodule

// File: rtl/uart_hex_formatter.sv
// Formats {addr, value} records as "AAAA<sep>VV<eol>" and strobes each character
// to a TX buffer, paced on the baud_x1 tick.
module uart_hex_formatter
  import uart_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = ASCII_COLON,
  parameter bit         EOL_CRLF = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               baud_x1,
  uart_hex_formatter_if.slave bus
);

  localparam logic [3:0] LAST_IDX = EOL_CRLF ? 4'd8 : 4'd7;

  fmt_state_e  state_q, state_d;
  logic        ready_q, ready_d;
  logic [7:0]  data_q, data_d;
  logic        strobe_q, strobe_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  value_q, value_d;

  logic [3:0]  sel_idx;
  logic [3:0]  nib;
  logic [7:0]  nib_ascii;
  logic [7:0]  char_sel;

  // STB_LO loads the following char, so the mux looks one index ahead there.
  always_comb begin
    sel_idx = (state_q == STB_LO) ? idx_q + 4'd1 : idx_q;
    case (sel_idx)
      4'd0:    nib = addr_q[15:12];
      4'd1:    nib = addr_q[11:8];
      4'd2:    nib = addr_q[7:4];
      4'd3:    nib = addr_q[3:0];
      4'd5:    nib = value_q[7:4];
      4'd6:    nib = value_q[3:0];
      default: nib = '0;
    endcase
  end

  nibble_to_hex_ascii u_hex (
    .nibble (nib),
    .ascii  (nib_ascii)
  );

  always_comb begin
    case (sel_idx)
      4'd4:    char_sel = SEP_CHAR;
      4'd7:    char_sel = EOL_CRLF ? ASCII_CR : ASCII_LF;
      4'd8:    char_sel = ASCII_LF;
      default: char_sel = nib_ascii;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    value_d  = value_q;
    case (state_q)
      IDLE: begin
        if (bus.req && ready_q) begin
          addr_d  = bus.addr;
          value_d = bus.value;
          ready_d = 1'b0;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (baud_x1) begin
          data_d   = char_sel;
          strobe_d = 1'b1;
          state_d  = STB_HI;
        end
      end
      STB_HI: begin
        if (baud_x1) begin
          strobe_d = 1'b0;
          state_d  = STB_LO;
        end
      end
      STB_LO: begin
        if (baud_x1) begin
          if (idx_q == LAST_IDX) begin
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d    = idx_q + 4'd1;
            data_d   = char_sel;
            strobe_d = 1'b1;
            state_d  = STB_HI;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      data_q   <= '0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
      addr_q   <= '0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      value_q  <= value_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.data        = data_q;
  assign bus.data_strobe = strobe_q;

endmodule
